// File: rtl/codec_init_pkg.sv
// Shared types and constants for the codec boot-time configuration sequencer.
package codec_init_pkg;

  localparam int ENTRY_W = 16;
  localparam int REG_W   = 8;
  localparam int DATA_W  = 8;

  localparam logic [ENTRY_W-1:0] CMD_END          = 16'hFFFF;
  localparam logic [REG_W-1:0]   CMD_DELAY_REG    = 8'hFF;
  localparam logic [6:0]         DEFAULT_DEV_ADDR = 7'h18;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FETCH,
    ST_SETUP,
    ST_STROBE_HI,
    ST_STROBE_LO,
    ST_WAIT_BUSY,
    ST_WAIT_IDLE,
    ST_GAP,
    ST_DELAY,
    ST_NEXT,
    ST_DONE,
    ST_ERROR
  } codec_state_e;

  // Byte idx of a transaction: 0 = address/RW, 1 = register, 2 = data.
  function automatic logic [7:0] pick_byte(input logic [6:0] addr, input logic rd,
                                           input logic [ENTRY_W-1:0] entry,
                                           input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = {addr, rd};
      2'd1:    b = entry[15:8];
      default: b = entry[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/codec_init_rom.sv
// Command table ROM: synchronous read with one cycle of latency.
// Contents come from the CMD_TABLE parameter (entry i at bits [16*i +: 16]).
module codec_init_rom
  import codec_init_pkg::*;
#(
  parameter int                          NUM_CMDS  = 32,
  parameter int                          IDX_W     = 5,
  parameter logic [NUM_CMDS*ENTRY_W-1:0] CMD_TABLE = {NUM_CMDS{CMD_END}}
) (
  input  logic               clk,
  input  logic [IDX_W-1:0]   addr,
  output logic [ENTRY_W-1:0] data
);

  logic [ENTRY_W-1:0] mem [NUM_CMDS];

  for (genvar i = 0; i < NUM_CMDS; i++) begin : g_mem
    assign mem[i] = CMD_TABLE[i*ENTRY_W +: ENTRY_W];
  end

  always_ff @(posedge clk) begin
    data <= mem[addr];
  end

endmodule

// File: rtl/codec_init_seq.sv
// Walks the codec command table and feeds each write byte-by-byte to the I2C master.
// Define CODEC_INIT_READBACK_EN to verify every register write with a read-back.
module codec_init_seq
  import codec_init_pkg::*;
#(
  parameter int                          NUM_CMDS      = 32,
  parameter logic [6:0]                  DEV_ADDR      = DEFAULT_DEV_ADDR,
  parameter int                          STROBE_CYCLES = 4,
  parameter int                          BUSY_TIMEOUT  = 1024,
  parameter int                          DELAY_UNIT    = 12000,
  parameter int                          GAP_CYCLES    = 64,
  parameter logic [NUM_CMDS*ENTRY_W-1:0] CMD_TABLE     = {NUM_CMDS{CMD_END}},
  localparam int                         IDX_W         = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [7:0]       i2c_din,
  output logic             i2c_copy_enable,
  input  logic             i2c_busy,
  input  logic [7:0]       i2c_dout,
  output logic             active,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] cmd_index,
  output codec_state_e     dbg_state
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CMDS - 1);

  // Handshake: i2c_din is stable from SETUP until the end of STROBE_LO; the master
  // latches it on the falling edge of i2c_copy_enable and raises i2c_busy while the
  // bus transaction runs; a transaction is finished once i2c_busy returns low.
  codec_state_e       state, state_n;
  logic [31:0]        cnt, cnt_n;
  logic [1:0]         byte_cnt, byte_n;
  logic [IDX_W-1:0]   idx_n;
  logic [7:0]         din_q, din_n;
  logic [ENTRY_W-1:0] rom_data;
  logic [REG_W-1:0]   entry_reg;
  logic [DATA_W-1:0]  entry_data;
  logic [31:0]        delay_cycles;
  logic [1:0]         last_byte;
  logic               rd_phase;

  codec_init_rom #(
    .NUM_CMDS  (NUM_CMDS),
    .IDX_W     (IDX_W),
    .CMD_TABLE (CMD_TABLE)
  ) u_rom (
    .clk  (clk),
    .addr (cmd_index),
    .data (rom_data)
  );

  assign entry_reg    = rom_data[15:8];
  assign entry_data   = rom_data[7:0];
  assign delay_cycles = 32'(entry_data) * 32'(DELAY_UNIT);
  // A verify read is two bytes (address+R, register); a write is three.
  assign last_byte    = rd_phase ? 2'd1 : 2'd2;

`ifdef CODEC_INIT_READBACK_EN
  logic rd_n;
  always_ff @(posedge clk) begin
    if (reset) rd_phase <= 1'b0;
    else       rd_phase <= rd_n;
  end
`else
  logic unused_dout;
  assign rd_phase    = 1'b0;
  assign unused_dout = ^i2c_dout;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      byte_cnt  <= '0;
      cmd_index <= '0;
      din_q     <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      byte_cnt  <= byte_n;
      cmd_index <= idx_n;
      din_q     <= din_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    byte_n  = byte_cnt;
    idx_n   = cmd_index;
    din_n   = din_q;
`ifdef CODEC_INIT_READBACK_EN
    rd_n    = rd_phase;
`endif
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_n = ST_LOAD;
          idx_n   = '0;
        end
      end
      ST_LOAD: state_n = ST_FETCH;
      ST_FETCH: begin
`ifdef CODEC_INIT_READBACK_EN
        rd_n = 1'b0;
`endif
        if (rom_data == CMD_END) begin
          state_n = ST_DONE;
        end else if (entry_reg == CMD_DELAY_REG) begin
          if (entry_data == '0) begin
            state_n = ST_NEXT;
          end else begin
            state_n = ST_DELAY;
            cnt_n   = delay_cycles - 32'd1;
          end
        end else begin
          state_n = ST_SETUP;
          byte_n  = 2'd0;
          cnt_n   = 32'd1;
          din_n   = pick_byte(DEV_ADDR, 1'b0, rom_data, 2'd0);
        end
      end
      ST_SETUP: begin
        if (cnt == '0) begin
          state_n = ST_STROBE_HI;
          cnt_n   = 32'(STROBE_CYCLES - 1);
        end else begin
          cnt_n = cnt - 32'd1;
        end
      end
      ST_STROBE_HI: begin
        if (cnt == '0) begin
          state_n = ST_STROBE_LO;
          cnt_n   = 32'(STROBE_CYCLES - 1);
        end else begin
          cnt_n = cnt - 32'd1;
        end
      end
      ST_STROBE_LO: begin
        if (cnt != '0) begin
          cnt_n = cnt - 32'd1;
        end else if (byte_cnt == last_byte) begin
          state_n = ST_WAIT_BUSY;
          cnt_n   = 32'(BUSY_TIMEOUT - 1);
        end else begin
          state_n = ST_SETUP;
          byte_n  = byte_cnt + 2'd1;
          cnt_n   = 32'd1;
          din_n   = pick_byte(DEV_ADDR, rd_phase, rom_data, byte_cnt + 2'd1);
        end
      end
      ST_WAIT_BUSY: begin
        if (i2c_busy) begin
          state_n = ST_WAIT_IDLE;
        end else if (cnt == '0) begin
          state_n = ST_ERROR;
        end else begin
          cnt_n = cnt - 32'd1;
        end
      end
      ST_WAIT_IDLE: begin
        if (!i2c_busy) begin
          state_n = ST_GAP;
          cnt_n   = 32'(GAP_CYCLES - 1);
`ifdef CODEC_INIT_READBACK_EN
          if (rd_phase && (i2c_dout != entry_data)) state_n = ST_ERROR;
`endif
        end
      end
      ST_GAP: begin
        if (cnt != '0) begin
          cnt_n = cnt - 32'd1;
        end else begin
          state_n = ST_NEXT;
`ifdef CODEC_INIT_READBACK_EN
          // The write just finished: issue the verify read of the same register.
          if (!rd_phase) begin
            state_n = ST_SETUP;
            rd_n    = 1'b1;
            byte_n  = 2'd0;
            cnt_n   = 32'd1;
            din_n   = pick_byte(DEV_ADDR, 1'b1, rom_data, 2'd0);
          end
`endif
        end
      end
      ST_DELAY: begin
        if (cnt == '0) state_n = ST_NEXT;
        else           cnt_n   = cnt - 32'd1;
      end
      ST_NEXT: begin
        // Running off the end of the table finishes with the last index held.
        if (cmd_index == LAST_IDX) begin
          state_n = ST_DONE;
        end else begin
          state_n = ST_LOAD;
          idx_n   = cmd_index + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign i2c_din         = din_q;
  assign i2c_copy_enable = (state == ST_STROBE_HI);
  assign done            = (state == ST_DONE);
  assign error           = (state == ST_ERROR);
  assign active          = !(state inside {ST_IDLE, ST_DONE, ST_ERROR});
  assign dbg_state       = state;

endmodule

// File: tb/tb_codec_init_seq.sv
// Bench for codec_init_seq: I2C master model with random busy timing and a
// timeline/byte model derived from the table.
module tb_codec_init_seq;
  import codec_init_pkg::*;

  localparam int NUM = 8;
  localparam int S   = 4;
  localparam int BT  = 1024;
  localparam int DU  = 10;
  localparam int GAP = 64;
  localparam int END_IDX = 6;
  localparam logic [NUM*16-1:0] TBL = {16'h0000, 16'hFFFF, 16'h5A5A, 16'hFF00,
                                       16'h2233, 16'hFF03, 16'h4011, 16'h0001};
`ifdef CODEC_INIT_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [7:0]   i2c_din;
  logic         i2c_copy_enable;
  logic         i2c_busy = 1'b0;
  logic [7:0]   i2c_dout = 8'h00;
  logic         active, done, error;
  logic [2:0]   cmd_index;
  codec_state_e dbg_state;

  codec_init_seq #(
    .NUM_CMDS(NUM), .STROBE_CYCLES(S), .BUSY_TIMEOUT(BT), .DELAY_UNIT(DU),
    .GAP_CYCLES(GAP), .CMD_TABLE(TBL)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .i2c_din(i2c_din),
    .i2c_copy_enable(i2c_copy_enable), .i2c_busy(i2c_busy), .i2c_dout(i2c_dout),
    .active(active), .done(done), .error(error), .cmd_index(cmd_index),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard / model state
  logic [7:0] exp_q[$];
  int         len_q[$];
  int         lat_q[$];
  int         exp_done_lat;
  int         checks = 0;
  int         errors = 0;
  int         mode = 0;  // 0 responsive, 1 never busy, 2 corrupt readback of reg 0x40

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Latencies: first rise is 4 cycles after start; a busy fall leads to the next
  // write's rise after GAP + NEXT + LOAD + read + 2 SETUP; each delay entry adds
  // d*DU plus its own NEXT/LOAD/read; a verify read follows its write's GAP directly.
  task automatic build_model(input bit rb);
    logic [15:0] e;
    int pending;
    exp_q.delete(); len_q.delete(); lat_q.delete();
    pending = 4;
    for (int i = 0; i < NUM; i++) begin
      e = TBL[i*16 +: 16];
      if (e == 16'hFFFF) break;
      if (e[15:8] == 8'hFF) begin
        pending += int'(e[7:0]) * DU + 3;
      end else begin
        lat_q.push_back(pending);
        exp_q.push_back(8'h30); exp_q.push_back(e[15:8]); exp_q.push_back(e[7:0]);
        len_q.push_back(3);
        if (rb) begin
          lat_q.push_back(GAP + 3);
          exp_q.push_back(8'h31); exp_q.push_back(e[15:8]);
          len_q.push_back(2);
        end
        pending = GAP + 6;
      end
    end
    exp_done_lat = pending - 2;
  endtask

  // I2C master model and per-cycle compare process
  logic       prev_ce = 1'b0, prev_active = 1'b0, prev_done = 1'b0, prev_error = 1'b0;
  int         rise_cyc = 0, fall_cyc = 0, ref_cyc = 0, nbyte = 0;
  int         busy_wait = -1, busy_left = 0;
  logic [7:0] din_hold = 8'h00;
  logic [7:0] txn [3];
  logic [7:0] regmap [256];

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_ce = 1'b0; prev_active = 1'b0; prev_done = 1'b0; prev_error = 1'b0;
        nbyte = 0; busy_wait = -1; busy_left = 0; i2c_busy = 1'b0;
      end else begin
        if (busy_wait > 0) begin
          busy_wait--;
        end else if (busy_wait == 0) begin
          i2c_busy = 1'b1; busy_left = 20; busy_wait = -1;
        end else if (busy_left > 0) begin
          busy_left--;
          if (busy_left == 0) begin
            i2c_busy = 1'b0;
            ref_cyc  = cyc;
          end
        end
        check("status_exclusive", ((int'(active) + int'(done) + int'(error)) > 1) ? 1 : 0, 0);
        if (active && !prev_active) begin
          ref_cyc = cyc;
          nbyte   = 0;
        end
        if (i2c_copy_enable && !prev_ce) begin
          if (nbyte == 0) begin
            if (lat_q.size() == 0) check("unexpected_txn", 1, 0);
            else                   check("txn_start_latency", cyc - ref_cyc, lat_q.pop_front());
          end else begin
            check("byte_period", cyc - rise_cyc, 2 + 2*S);
          end
          rise_cyc = cyc;
          din_hold = i2c_din;
        end
        if (i2c_copy_enable && prev_ce) check("din_stable", i2c_din, din_hold);
        if (!i2c_copy_enable && prev_ce) begin
          check("strobe_width", cyc - rise_cyc, S);
          fall_cyc = cyc;
          if (exp_q.size() == 0) check("extra_byte", i2c_din, -1);
          else                   check("latched_byte", i2c_din, exp_q.pop_front());
          if (nbyte < 3) txn[nbyte] = i2c_din;
          nbyte++;
          if (len_q.size() > 0 && nbyte == len_q[0]) begin
            void'(len_q.pop_front());
            nbyte = 0;
            if (txn[0][0]) i2c_dout = (mode == 2 && txn[1] == 8'h40) ? 8'h10 : regmap[txn[1]];
            else           regmap[txn[1]] = txn[2];
            if (mode != 1) busy_wait = $urandom_range(0, 30);
          end else if (nbyte >= 3) begin
            nbyte = 0;
          end
        end
        if (done && !prev_done) check("done_latency", cyc - ref_cyc, exp_done_lat);
        if (error && !prev_error && mode == 1) check("timeout_latency", cyc - fall_cyc, S + BT);
        prev_ce = i2c_copy_enable; prev_active = active;
        prev_done = done; prev_error = error;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n;
    n = 0;
    while (!(done || error) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("run_ends_in_budget", int'(n < budget), 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_copy_enable"}, i2c_copy_enable, 0);
    check({tag, "_active"}, active, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_cmd_index"}, cmd_index, 0);
    check({tag, "_din"}, i2c_din, 0);
  endtask

  initial begin
    int rises;
    logic pce;
    for (int i = 0; i < 256; i++) regmap[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_state", int'(dbg_state), int'(ST_IDLE));
    reset = 1'b0;

    // Model pins, hand-derived from the table
    build_model(RB);
    check("model_byte1", exp_q[1], 8'h00);
    check("model_byte2", exp_q[2], 8'h01);
`ifdef CODEC_INIT_READBACK_EN
    check("model_nbytes", exp_q.size(), 20);
    check("model_delay_lat", lat_q[4], 103);
    check("model_wr_byte", exp_q[7], 8'h11);
`else
    check("model_nbytes", exp_q.size(), 12);
    check("model_delay_lat", lat_q[2], 103);
    check("model_wr_byte", exp_q[5], 8'h11);
`endif
    check("model_done_lat", exp_done_lat, 68);

    // Full table, with a stray start pulse while active
    mode = 0;
    pulse_start();
    repeat ($urandom_range(20, 150)) @(negedge clk);
    check("active_before_stray_start", active, 1);
    pulse_start();
    wait_end(5000);
    repeat (3) @(negedge clk);
    check("a_done", done, 1);
    check("a_error", error, 0);
    check("a_active", active, 0);
    check("a_cmd_index", cmd_index, END_IDX);
    check("a_bytes_left", exp_q.size(), 0);
    check("a_txns_left", lat_q.size(), 0);

    // Master never goes busy: timeout on entry 0
    build_model(RB);
    mode = 1;
    pulse_start();
    wait_end(3000);
    repeat (5) @(negedge clk);
    check("b_error", error, 1);
    check("b_done", done, 0);
    check("b_active", active, 0);
    check("b_cmd_index", cmd_index, 0);
    check("b_copy_enable", i2c_copy_enable, 0);

    // Reset during STROBE_HI of byte 2, then a clean re-run
    build_model(RB);
    mode = 0;
    pulse_start();
    rises = 0;
    pce = 1'b0;
    for (int i = 0; i < 300 && rises < 2; i++) begin
      @(negedge clk);
      if (i2c_copy_enable && !pce) rises++;
      pce = i2c_copy_enable;
    end
    check("c_second_strobe_seen", rises, 2);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("c_reset");
    @(negedge clk);
    build_model(RB);
    reset = 1'b0;
    pulse_start();
    wait_end(5000);
    @(negedge clk);
    check("c_done", done, 1);
    check("c_cmd_index", cmd_index, END_IDX);
    check("c_bytes_left", exp_q.size(), 0);

`ifdef CODEC_INIT_READBACK_EN
    // Readback of register 0x40 returns 0x10 instead of 0x11
    build_model(RB);
    mode = 2;
    pulse_start();
    wait_end(5000);
    @(negedge clk);
    check("d_error", error, 1);
    check("d_done", done, 0);
    check("d_cmd_index", cmd_index, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
